// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder/scanner: operating modes and output width derivation.
package decoder_pkg;

    typedef enum logic [1:0] {
        ModeOff    = 2'b00,
        ModeDecode = 2'b01,
        ModeScan   = 2'b10,
        ModeHold   = 2'b11
    } mode_e;

    function automatic int unsigned out_width(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational index-to-one-hot conversion.
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    localparam int unsigned OUT_W = out_width(SEL_W)
) (
    input  logic [SEL_W-1:0] i_idx,
    output logic [OUT_W-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_idx] = 1'b1;
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered select decoder with a dwell-timed scanning mode, hold and off modes.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 4,
    localparam int unsigned OUT_W  = out_width(SEL_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    input  logic [SEL_W-1:0]   in_sel,
    output logic               in_ready,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic [SEL_W-1:0]   out_idx,
    output logic               wrap
);

    mode_e              r_st;
    logic [OUT_W-1:0]   r_out;
    logic [SEL_W-1:0]   r_idx;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_wrap;

    logic               w_out_on;
    logic               w_due;
    logic [SEL_W-1:0]   w_idx_inc;
    logic [SEL_W-1:0]   w_oh_idx;
    logic [OUT_W-1:0]   w_oh;

    assign w_out_on  = |r_out;
    assign w_due     = (r_cnt >= dwell);
    assign w_idx_inc = r_idx + 1'b1;

    // One converter serves all three sources: new select, scan entry, scan advance.
    always_comb begin
        w_oh_idx = r_idx;
        if (r_st == ModeDecode) begin
            w_oh_idx = in_sel;
        end else if (w_out_on) begin
            w_oh_idx = w_idx_inc;
        end
    end

    decoder_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .i_idx    (w_oh_idx),
        .o_onehot (w_oh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st   <= ModeOff;
            r_out  <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_st   <= mode_e'(mode);
            r_wrap <= 1'b0;
            unique case (r_st)
                ModeOff: begin
                    r_out <= '0;
                    r_cnt <= '0;
                end
                ModeDecode: begin
                    r_cnt <= '0;
                    if (in_valid) begin
                        r_out <= w_oh;
                        r_idx <= in_sel;
                    end
                end
                ModeScan: begin
                    if (!w_out_on) begin
                        r_out <= w_oh;
                        r_cnt <= '0;
                    end else if (w_due) begin
                        r_out  <= w_oh;
                        r_idx  <= w_idx_inc;
                        r_cnt  <= '0;
                        r_wrap <= &r_idx;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // Leaving scan drops partial dwell so re-entry gets a full one.
                    if (mode_e'(mode) != ModeScan) begin
                        r_cnt <= '0;
                    end
                end
                ModeHold: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready = (r_st == ModeDecode);
    assign out      = r_out;
    assign out_idx  = r_idx;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: default (8-bit) and SEL_W=4 (16-bit) instances vs a cycle model.
module tb_decoder_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_sel = 3'd0;
    logic [3:0]  in_sel16 = 4'd0;
    logic [3:0]  dwell = 4'd0;

    logic        in_ready8, in_ready16;
    logic [7:0]  out8;
    logic [15:0] out16;
    logic [2:0]  idx8;
    logic [3:0]  idx16;
    logic        wrap8, wrap16;

    int checks = 0;
    int errors = 0;

    // Behavioural model state, [0] = 8-output instance, [1] = 16-output instance.
    int m_st[2];
    int m_on[2];
    int m_idx[2];
    int m_cnt[2];
    int m_wrap[2];

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(3), .DWELL_W(4)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_ready (in_ready8),
        .dwell    (dwell),
        .out      (out8),
        .out_idx  (idx8),
        .wrap     (wrap8)
    );

    decoder_scan #(.SEL_W(4), .DWELL_W(4)) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .in_valid (in_valid),
        .in_sel   (in_sel16),
        .in_ready (in_ready16),
        .dwell    (dwell),
        .out      (out16),
        .out_idx  (idx16),
        .wrap     (wrap16)
    );

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_st[u] = 0; m_on[u] = 0; m_idx[u] = 0; m_cnt[u] = 0; m_wrap[u] = 0;
        end
    endtask

    // Advance one clock: predict from pre-edge inputs, then compare both instances.
    task automatic tick(input string tag);
        int ns[2], no[2], ni[2], nc[2], nw[2];
        int ow, sel;
        logic [15:0] exp;
        for (int u = 0; u < 2; u++) begin
            ow  = (u == 0) ? 8 : 16;
            sel = (u == 0) ? int'(in_sel) : int'(in_sel16);
            ns[u] = int'(mode); no[u] = m_on[u]; ni[u] = m_idx[u];
            nc[u] = m_cnt[u]; nw[u] = 0;
            case (m_st[u])
                0: begin no[u] = 0; nc[u] = 0; end
                1: begin
                    nc[u] = 0;
                    if (in_valid) begin no[u] = 1; ni[u] = sel; end
                end
                2: begin
                    if (m_on[u] == 0) begin
                        no[u] = 1; nc[u] = 0;
                    end else if (m_cnt[u] >= int'(dwell)) begin
                        nc[u] = 0;
                        ni[u] = (m_idx[u] + 1) % ow;
                        nw[u] = (ni[u] == 0) ? 1 : 0;
                    end else begin
                        nc[u] = m_cnt[u] + 1;
                    end
                    if (mode != 2'd2) nc[u] = 0;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            m_st[u] = ns[u]; m_on[u] = no[u]; m_idx[u] = ni[u];
            m_cnt[u] = nc[u]; m_wrap[u] = nw[u];
        end
        exp = (m_on[0] != 0) ? (16'd1 << m_idx[0]) : 16'd0;
        checks++;
        if (out8 !== exp[7:0]) begin
            errors++; $display("FAIL %s out8 got %h want %h", tag, out8, exp[7:0]);
        end
        checks++;
        if (int'(idx8) != m_idx[0] || $isunknown(idx8)) begin
            errors++; $display("FAIL %s idx8 got %0d want %0d", tag, idx8, m_idx[0]);
        end
        checks++;
        if (wrap8 !== m_wrap[0][0]) begin
            errors++; $display("FAIL %s wrap8 got %b want %0d", tag, wrap8, m_wrap[0]);
        end
        checks++;
        if (in_ready8 !== (m_st[0] == 1)) begin
            errors++; $display("FAIL %s ready8 got %b want %0d", tag, in_ready8, m_st[0] == 1);
        end
        exp = (m_on[1] != 0) ? (16'd1 << m_idx[1]) : 16'd0;
        checks++;
        if (out16 !== exp) begin
            errors++; $display("FAIL %s out16 got %h want %h", tag, out16, exp);
        end
        checks++;
        if (int'(idx16) != m_idx[1] || $isunknown(idx16)) begin
            errors++; $display("FAIL %s idx16 got %0d want %0d", tag, idx16, m_idx[1]);
        end
        checks++;
        if (wrap16 !== m_wrap[1][0]) begin
            errors++; $display("FAIL %s wrap16 got %b want %0d", tag, wrap16, m_wrap[1]);
        end
        checks++;
        if (in_ready16 !== (m_st[1] == 1)) begin
            errors++; $display("FAIL %s ready16 got %b want %0d", tag, in_ready16, m_st[1] == 1);
        end
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        checks++;
        if (out8 !== 8'h00 || idx8 !== 3'd0 || wrap8 !== 1'b0 || in_ready8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8 got out=%h idx=%0d wrap=%b rdy=%b want 0", out8, idx8, wrap8,
                     in_ready8);
        end
        checks++;
        if (out16 !== 16'h0 || idx16 !== 4'd0 || wrap16 !== 1'b0 || in_ready16 !== 1'b0) begin
            errors++;
            $display("FAIL reset16 got out=%h idx=%0d wrap=%b rdy=%b want 0", out16, idx16, wrap16,
                     in_ready16);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("reset_idle");
    endtask

    task automatic test_decode();
        mode = 2'd1;
        tick("dec_enter");
        checks++;
        if (in_ready8 !== 1'b1) begin
            errors++; $display("FAIL dec_ready got %b want 1", in_ready8);
        end
        in_valid = 1'b1; in_sel = 3'd5; in_sel16 = 4'd9;
        tick("dec_sel5");
        in_valid = 1'b0;
        checks++;
        if (out8 !== 8'b0010_0000 || idx8 !== 3'd5) begin
            errors++; $display("FAIL dec_sel5 got out=%b idx=%0d want 00100000 idx 5", out8, idx8);
        end
    endtask

    task automatic test_scan_seq();
        int seq[10];
        seq = '{5, 5, 5, 6, 6, 6, 7, 7, 7, 0};
        mode = 2'd2; dwell = 4'd2;
        for (int i = 0; i < 10; i++) begin
            tick("scan_seq");
            checks++;
            if (int'(idx8) != seq[i] || wrap8 !== (i == 9)) begin
                errors++;
                $display("FAIL scan_seq[%0d] got idx=%0d wrap=%b want idx=%0d wrap=%0d", i, idx8,
                         wrap8, seq[i], i == 9);
            end
        end
    endtask

    task automatic test_scan_dwell0();
        int w8, w16;
        w8 = 0; w16 = 0;
        dwell = 4'd0;
        for (int i = 0; i < 32; i++) begin
            tick("dwell0");
            if (wrap8 === 1'b1) w8++;
            if (wrap16 === 1'b1) begin
                w16++;
                checks++;
                if (idx16 !== 4'd0 || out16 !== 16'h0001) begin
                    errors++; $display("FAIL wrap16_pos got idx=%0d out=%h want 0 0001", idx16, out16);
                end
            end
        end
        checks++;
        if (w8 != 4 || w16 != 2) begin
            errors++; $display("FAIL dwell0_wraps got %0d/%0d want 4/2", w8, w16);
        end
    endtask

    task automatic test_hold();
        int frozen;
        dwell = 4'd3;
        for (int i = 0; i < 5; i++) tick("pre_hold");
        mode = 2'd3;
        tick("hold_enter");
        frozen = m_idx[0];
        for (int i = 0; i < 5; i++) begin
            tick("hold");
            checks++;
            if (int'(idx8) != frozen || out8 !== (8'd1 << frozen)) begin
                errors++; $display("FAIL hold got idx=%0d out=%h want idx=%0d", idx8, out8, frozen);
            end
        end
        mode = 2'd2;
        for (int i = 0; i < 5; i++) begin
            tick("resume");
            checks++;
            if (int'(idx8) != ((i < 4) ? frozen : (frozen + 1) % 8)) begin
                errors++; $display("FAIL resume[%0d] got idx=%0d frozen=%0d", i, idx8, frozen);
            end
        end
    endtask

    task automatic test_off();
        int saved;
        mode = 2'd0; in_valid = 1'b1; in_sel = 3'd3; in_sel16 = 4'd3;
        tick("off_enter");
        saved = m_idx[0];
        for (int i = 0; i < 3; i++) begin
            tick("off");
            checks++;
            if (out8 !== 8'h00 || int'(idx8) != saved || in_ready8 !== 1'b0) begin
                errors++; $display("FAIL off got out=%h idx=%0d want 00 idx=%0d", out8, idx8, saved);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) dwell = 4'($urandom_range(0, 4));
            in_valid = 1'($urandom);
            in_sel   = 3'($urandom);
            in_sel16 = 4'($urandom);
            tick("random");
        end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        mode = 2'd2; dwell = 4'd1;
        for (int i = 0; i < 20 && (m_idx[0] == 0 || m_on[0] == 0); i++) tick("pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out8 !== 8'h00 || idx8 !== 3'd0 || wrap8 !== 1'b0 || in_ready8 !== 1'b0) begin
            errors++; $display("FAIL async_rst8 got out=%h idx=%0d wrap=%b want 0", out8, idx8, wrap8);
        end
        checks++;
        if (out16 !== 16'h0 || idx16 !== 4'd0 || wrap16 !== 1'b0) begin
            errors++; $display("FAIL async_rst16 got out=%h idx=%0d wrap=%b want 0", out16, idx16,
                               wrap16);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("post_rst0");
        tick("post_rst1");
        checks++;
        if (out8 !== 8'h01 || idx8 !== 3'd0) begin
            errors++; $display("FAIL post_rst_entry got out=%h idx=%0d want 01 idx 0", out8, idx8);
        end
        dwell = 4'd0;
        for (int i = 0; i < 20; i++) tick("post_rst_scan");
    endtask

    initial begin
        test_reset();
        test_decode();
        test_scan_seq();
        test_scan_dwell0();
        test_hold();
        test_off();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
